mem_port_arbiter: RTL and testbench

- Shares the single external memory port between instruction fetch (IF) and the data cache (D) of the RV32I pipeline.
- Accepts level-held requests from both masters and grants one at a time.
- Drives the memory bus for a fixed MEM_LATENCY, returns read data and a one-cycle ack to the owner.
- Data has priority, with a starvation guard for fetch.

---
 rtl/mem_port_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one external memory port between instruction
// fetch (IF) and the data cache (D). Data wins contested grants, except
// that after STARVE_LIMIT consecutive contested data grants fetch is
// forced through. Every transaction holds the bus for MEM_LATENCY cycles,
// then pulses a one-cycle ack to its owner in a response cycle.
module mem_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic [XLEN-1:0] if_rdata,
    output logic            if_ack,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    input  logic [3:0]      d_be,
    output logic [XLEN-1:0] d_rdata,
    output logic            d_ack,
    output logic            mem_en,
    output logic            mem_we,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            busy
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int STK_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(MEM_LATENCY - 1);
    localparam logic [STK_W-1:0] STK_LIMIT = STK_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [STK_W-1:0] streak, streak_nxt;
    logic             owner_d, owner_d_nxt;

    logic [XLEN-1:0]  if_rdata_nxt, d_rdata_nxt;
    logic [XLEN-1:0]  mem_addr_nxt, mem_wdata_nxt;
    logic [3:0]       mem_be_nxt;
    logic             if_ack_nxt, d_ack_nxt;
    logic             mem_en_nxt, mem_we_nxt, busy_nxt;

    logic             any_req;
    logic             grant_d;

    // Arbitration: data wins unless fetch has been starved long enough.
    assign any_req = if_req | d_req;
    assign grant_d = d_req & (~if_req | (streak != STK_LIMIT));

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = BUSY;
            BUSY:    if (cnt == '0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs and bookkeeping counters.
    always_comb begin
        cnt_nxt       = cnt;
        streak_nxt    = streak;
        owner_d_nxt   = owner_d;
        if_rdata_nxt  = if_rdata;
        d_rdata_nxt   = d_rdata;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        mem_be_nxt    = mem_be;
        mem_en_nxt    = mem_en;
        mem_we_nxt    = mem_we;
        busy_nxt      = busy;
        if_ack_nxt    = 1'b0;
        d_ack_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    owner_d_nxt = grant_d;
                    mem_en_nxt  = 1'b1;
                    busy_nxt    = 1'b1;
                    cnt_nxt     = CNT_LOAD;
                    if (grant_d) begin
                        mem_we_nxt    = d_we;
                        mem_be_nxt    = d_we ? d_be : 4'hF;
                        mem_addr_nxt  = d_addr;
                        mem_wdata_nxt = d_wdata;
                        // Only a data grant that beat a waiting fetch counts.
                        if (if_req) begin
                            streak_nxt = (streak == STK_LIMIT) ? streak : streak + 1'b1;
                        end else begin
                            streak_nxt = '0;
                        end
                    end else begin
                        mem_we_nxt   = 1'b0;
                        mem_be_nxt   = 4'hF;
                        mem_addr_nxt = if_addr;
                        streak_nxt   = '0;
                    end
                end
            end
            BUSY: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    // Last bus cycle: read data is valid now, so capture it.
                    mem_en_nxt = 1'b0;
                    mem_we_nxt = 1'b0;
                    if (owner_d) begin
                        d_ack_nxt = 1'b1;
                        if (!mem_we) d_rdata_nxt = mem_rdata;
                    end else begin
                        if_ack_nxt   = 1'b1;
                        if_rdata_nxt = mem_rdata;
                    end
                end
            end
            RESP: begin
                busy_nxt = 1'b0;
            end
            default: begin
                mem_en_nxt = 1'b0;
                mem_we_nxt = 1'b0;
                busy_nxt   = 1'b0;
            end
        endcase
    end

    // Output and bookkeeping registers; reset clears the bus at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            streak    <= '0;
            owner_d   <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= 4'h0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            busy      <= 1'b0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            streak    <= streak_nxt;
            owner_d   <= owner_d_nxt;
            if_rdata  <= if_rdata_nxt;
            d_rdata   <= d_rdata_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            mem_be    <= mem_be_nxt;
            mem_en    <= mem_en_nxt;
            mem_we    <= mem_we_nxt;
            busy      <= busy_nxt;
            if_ack    <= if_ack_nxt;
            d_ack     <= d_ack_nxt;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by random
// request traffic, checked against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int L  = 2;
    localparam int SL = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0]  d_be;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_ack, d_ack, mem_en, mem_we, busy;
    logic [3:0]  mem_be;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    int          m_streak;
    logic [31:0] m_if_rdata, m_d_rdata;

    mem_port_arbiter #(.XLEN(32), .MEM_LATENCY(L), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk1({tag, "_mem_en"}, mem_en, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_if_ack"}, if_ack, 1'b0);
        chk1({tag, "_d_ack"}, d_ack, 1'b0);
    endtask

    // One whole transaction. Called at the negedge of the IDLE cycle in
    // which the requests are first seen; returns at the negedge of the
    // following IDLE cycle.
    task automatic do_txn(input bit drop_early, input logic [31:0] rd, output bit won_d);
        bit          wd, we;
        logic [31:0] ea, ew;
        logic [3:0]  eb;
        wd    = d_req && (!if_req || m_streak != SL);
        won_d = wd;
        we    = wd && d_we;
        ea    = wd ? d_addr : if_addr;
        ew    = d_wdata;
        eb    = we ? d_be : 4'hF;
        if (wd) m_streak = if_req ? ((m_streak < SL) ? m_streak + 1 : SL) : 0;
        else    m_streak = 0;
        mem_rdata = $urandom;
        for (int k = 1; k <= L; k++) begin
            @(negedge clk);
            if (k == 1 && drop_early) begin
                if (wd) d_req = 1'b0;
                else    if_req = 1'b0;
            end
            chk1("bus_mem_en", mem_en, 1'b1);
            chk1("bus_mem_we", mem_we, we);
            chk32("bus_mem_be", {28'd0, mem_be}, {28'd0, eb});
            chk32("bus_mem_addr", mem_addr, ea);
            if (wd) chk32("bus_mem_wdata", mem_wdata, ew);
            chk1("bus_busy", busy, 1'b1);
            chk1("bus_if_ack", if_ack, 1'b0);
            chk1("bus_d_ack", d_ack, 1'b0);
            mem_rdata = (k == L) ? rd : $urandom;
        end
        @(negedge clk);
        if (wd && !we) m_d_rdata = rd;
        if (!wd)       m_if_rdata = rd;
        chk1("resp_if_ack", if_ack, !wd);
        chk1("resp_d_ack", d_ack, wd);
        chk1("resp_mem_en", mem_en, 1'b0);
        chk1("resp_mem_we", mem_we, 1'b0);
        chk1("resp_busy", busy, 1'b1);
        chk32("resp_mem_addr", mem_addr, ea);
        chk32("resp_if_rdata", if_rdata, m_if_rdata);
        chk32("resp_d_rdata", d_rdata, m_d_rdata);
        if (wd) d_req = 1'b0;
        else    if_req = 1'b0;
        mem_rdata = $urandom;
        @(negedge clk);
        chk_idle("after_resp");
    endtask

    initial begin
        bit w;
        rst_n = 1'b0;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0; mem_rdata = '0;
        m_streak = 0; m_if_rdata = '0; m_d_rdata = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk_idle("reset");
        chk32("reset_if_rdata", if_rdata, 32'h0);
        chk32("reset_d_rdata", d_rdata, 32'h0);
        chk32("reset_mem_addr", mem_addr, 32'h0);
        chk32("reset_mem_be", {28'd0, mem_be}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle("idle_no_req");

        // IF-only read.
        if_req = 1'b1; if_addr = 32'h100;
        do_txn(1'b0, 32'h00000013, w);
        chk1("s1_winner_if", w, 1'b0);
        chk32("s1_if_rdata", if_rdata, 32'h00000013);

        // D store leaves d_rdata untouched.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2004; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
        do_txn(1'b0, 32'h55AA55AA, w);
        chk1("s2_winner_d", w, 1'b1);
        chk32("s2_d_rdata", d_rdata, 32'h0);

        // Simultaneous requests: D load first, then IF.
        if_req = 1'b1; if_addr = 32'h200;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000;
        do_txn(1'b0, 32'hCAFE0001, w);
        chk1("s3_first_d", w, 1'b1);
        chk32("s3_d_rdata", d_rdata, 32'hCAFE0001);
        do_txn(1'b0, 32'hCAFE0002, w);
        chk1("s3_second_if", w, 1'b0);
        chk32("s3_if_rdata", if_rdata, 32'hCAFE0002);

        // Starvation guard: three D wins, then IF, then D again.
        for (int g = 0; g < 5; g++) begin
            if_req = 1'b1; if_addr = 32'h400 + 32'(g * 4);
            d_req = 1'b1; d_we = 1'b0; d_addr = 32'h5000 + 32'(g * 4);
            do_txn(1'b0, $urandom, w);
            chk1($sformatf("s4_grant%0d", g), w, (g == 3) ? 1'b0 : 1'b1);
        end
        if_req = 1'b0;
        @(negedge clk);
        chk_idle("s4_drain");

        // Async reset in the middle of a BUSY read.
        if_req = 1'b1; if_addr = 32'h700;
        mem_rdata = 32'h12345678;
        @(negedge clk);
        chk1("s5_busy_c1", mem_en, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        if_req = 1'b0;
        #1;
        chk_idle("s5_async");
        chk32("s5_if_rdata", if_rdata, 32'h0);
        m_streak = 0; m_if_rdata = '0; m_d_rdata = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk_idle($sformatf("s5_post%0d", c));
        end
        if_req = 1'b1; if_addr = 32'h100;
        do_txn(1'b0, 32'h00000013, w);
        chk32("s5_rerun_if_rdata", if_rdata, 32'h00000013);

        // Requester drops req during BUSY: completes, then nothing more.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h6000;
        do_txn(1'b1, 32'h0BADF00D, w);
        chk1("s6_winner_d", w, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_idle($sformatf("s6_idle%0d", c));
        end

        // Random traffic against the model.
        for (int t = 0; t < 60; t++) begin
            if (!if_req && $urandom_range(0, 1) == 1) begin
                if_req = 1'b1; if_addr = $urandom;
            end
            if (!d_req && $urandom_range(0, 2) != 0) begin
                d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom;
                d_wdata = $urandom; d_be = 4'($urandom_range(0, 15));
            end
            if (if_req || d_req) begin
                do_txn(1'($urandom_range(0, 7) == 0), $urandom, w);
            end else begin
                @(negedge clk);
                chk_idle("rand_idle");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
